tty_uart_tx: RTL and testbench
==============================

# tty_uart_tx

Byte-serial TTY transmitter downstream of the MCU system bus decoder. It consumes the decoder's TTY write strobe and write data, queues the low byte of each accepted write in a small FIFO, and serializes the bytes onto a UART line as 8N1 frames. It is write-only: no read data is returned to the bus, and the bus decoder returns 0 for TTY reads.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥ 2
- FIFO_DEPTH, 4, byte entries in the FIFO; must be a power of two, ≥ 2

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge
- rst_n_i  in  1  reset; synchronous and active-low
- tty_we_i  in  1  write strobe from the bus decoder; one cycle high = one write
- tty_data_i  in  32  write data; only bits [7:0] are used, bits [31:8] are ignored
- tx_o  out  1  UART serial output, registered; idle level is 1
- busy_o  out  1  high while the FSM is not in IDLE
- fifo_empty_o  out  1  high when the FIFO count is 0
- fifo_full_o  out  1  high when the FIFO count equals FIFO_DEPTH
- drop_o  out  1  one-cycle pulse when a write is rejected because the FIFO is full

## Operation
- **Reset** (rst_n_i=0 at an edge):
  - Outputs: tx_o=1, busy_o=0, fifo_empty_o=1, fifo_full_o=0, drop_o=0.
  - Internal: FSM goes to IDLE; FIFO pointers, count, bit counter and baud counter clear to 0.
  - Reset mid-frame aborts the frame immediately and discards all queued bytes.
- **Push:**
  - A write is accepted when tty_we_i=1 and fifo_full_o=0, using the registered value at that edge.
  - An accepted write stores tty_data_i[7:0] at the write pointer.
  - A write with fifo_full_o=1 is dropped, even if a pop happens in the same cycle; drop_o=1 for the following cycle.
- **Pop:** occurs on the FSM transition into START; it loads the head byte into the 8-bit shift register.
- **Push and pop in the same cycle:** both take effect; the count is unchanged.
- **Pointers:** log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- **FSM states:** IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
  - IDLE: tx_o=1. If fifo_empty_o=0, pop and go to START.
  - START: tx_o=0 for one bit time, then go to DATA with bit index 0.
  - DATA: tx_o = shift register bit 0 (LSB first). The register shifts right at each bit boundary. After bit index 7 completes, go to STOP.
  - STOP: tx_o=1 for one bit time. At the end of the bit, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **tx_o register:** tx_o is registered from the next-state value, so each level change is visible starting at the edge where the state or bit changes.

## Timing
- **Latency:** a write sampled at edge E into an empty FIFO with the FSM in IDLE gives fifo_empty_o=0 after E. The pop happens at E+1, and tx_o=0 and busy_o=1 from E+1.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles from the tx_o falling edge to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **busy_o:** falls at the edge where STOP → IDLE. There is a minimum of one IDLE cycle before any new frame that follows an IDLE state.
- **Status flags:** fifo_full_o and fifo_empty_o update at the same edge as the push or pop that changes the count.
- **drop_o:** never asserts for two consecutive cycles unless writes to a full FIFO occur on consecutive cycles.

## Test plan
Scenarios 1–5 use CLKS_PER_BIT=4 and FIFO_DEPTH=4; scenario 6 uses the default parameters.

1. **Single write:** one write of 0x000000A5 while idle.
   - tx_o sequence, 4 cycles per level: 0, 1,0,1,0,0,1,0,1, 1.
   - busy_o is high for exactly 40 cycles.
   - fifo_empty_o returns to 1 one cycle after the write.
2. **Upper bits ignored:** write 0xDEADBE41.
   - The frame carries 0x41 (data bits 1,0,0,0,0,0,1,0).
   - There is no other effect.
3. **Overflow:** tty_we_i=1 on 6 consecutive cycles with data 0x01..0x06.
   - Count goes 1,1,2,3,4, then fifo_full_o=1.
   - The 6th write is dropped and drop_o pulses once.
   - Frames 0x01..0x05 are sent back to back, 200 cycles total, with no idle gaps.
4. **Drain:** two queued bytes 0x00 and 0xFF.
   - The stop bit of frame 1 is followed directly by the start bit of frame 2.
   - busy_o stays high for 80 cycles.
   - fifo_empty_o=1 from the second pop onward.
5. **Reset mid-frame:** 3 bytes queued, rst_n_i=0 for one cycle during DATA bit 3.
   - After that edge: tx_o=1, busy_o=0, fifo_empty_o=1.
   - No further frames are sent.
6. **Default baud and FIFO full/pop:**
   - With CLKS_PER_BIT=16, write 0x55; each bit lasts 16 cycles.
   - Then fill the FIFO to 4 and write while a pop occurs in the same cycle: the write is dropped and the count is 3 after the edge.

Source files
------------

// File: rtl/tty_uart_tx.sv
// tty_uart_tx: write-only TTY transmitter. Queues the low byte of each bus write in a
// small FIFO and serializes queued bytes as 8N1 UART frames, LSB first.
module tty_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        tty_we_i,
   input  logic [31:0] tty_data_i,
   output logic        tx_o,
   output logic        busy_o,
   output logic        fifo_empty_o,
   output logic        fifo_full_o,
   output logic        drop_o
);

   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_count;
   logic [CntW-1:0] w_count_next;
   logic            r_drop;

   // Serializer state
   state_e          r_state;
   state_e          w_state_next;
   logic [BaudW-1:0] r_baud;
   logic [BaudW-1:0] w_baud_next;
   logic [2:0]      r_bit_idx;
   logic [2:0]      w_bit_idx_next;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_next;
   logic            r_tx;
   logic            w_tx_next;

   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;
   logic w_baud_end;

   // Upper write-data bits carry no meaning for this peripheral.
   logic w_unused_data;
   assign w_unused_data = ^tty_data_i[31:8];

   assign w_full     = (r_count == CntFull);
   assign w_empty    = (r_count == '0);
   // A full FIFO rejects the write even if a pop frees a slot on the same edge.
   assign w_push     = tty_we_i & ~w_full;
   assign w_baud_end = (r_baud == BaudLast);

   // FIFO occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - CntW'(1);
      end
   end

   // FIFO data array; contents need no reset since the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tty_data_i[7:0];
      end
   end

   // FIFO pointers, count and the one-cycle drop pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_drop   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         r_count <= w_count_next;
         r_drop  <= tty_we_i & w_full;
      end
   end

   // Frame sequencer next-state: pops on every entry into START, including from STOP.
   always_comb begin
      w_state_next   = r_state;
      w_baud_next    = r_baud;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_pop          = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = StStart;
               w_shift_next = r_mem[r_rd_ptr];
               w_baud_next  = '0;
            end
         end
         StStart: begin
            if (w_baud_end) begin
               w_state_next   = StData;
               w_baud_next    = '0;
               w_bit_idx_next = '0;
            end else begin
               w_baud_next = r_baud + BaudW'(1);
            end
         end
         StData: begin
            if (w_baud_end) begin
               w_baud_next  = '0;
               w_shift_next = {1'b0, r_shift[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_next = StStop;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_next = r_baud + BaudW'(1);
            end
         end
         StStop: begin
            if (w_baud_end) begin
               w_baud_next = '0;
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = StStart;
                  w_shift_next = r_mem[r_rd_ptr];
               end else begin
                  w_state_next = StIdle;
               end
            end else begin
               w_baud_next = r_baud + BaudW'(1);
            end
         end
         default: begin
            w_state_next = StIdle;
            w_baud_next  = '0;
         end
      endcase
   end

   // Line level derived from the next state so tx_o changes on the same edge as the state.
   always_comb begin
      w_tx_next = 1'b1;
      unique case (w_state_next)
         StStart: w_tx_next = 1'b0;
         StData:  w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   // Sequencer registers; reset aborts any frame in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state   <= StIdle;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_baud    <= w_baud_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
         r_tx      <= w_tx_next;
      end
   end

   assign tx_o         = r_tx;
   assign busy_o       = (r_state != StIdle);
   assign fifo_empty_o = w_empty;
   assign fifo_full_o  = w_full;
   assign drop_o       = r_drop;

endmodule

// File: tb/tb_tty_uart_tx.sv
// tb_tty_uart_tx: scoreboard bench. Tasks push expected bytes when writes are driven;
// a per-DUT line monitor decodes each frame cycle by cycle and pops/compares.
module tb_tty_uart_tx;

   localparam int unsigned CpbA   = 4;
   localparam int unsigned DepthA = 4;
   localparam int unsigned CpbB   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run    = 0;
   int tests_failed = 0;
   int frames_a     = 0;
   int frames_b     = 0;
   bit abort_a      = 1'b0;

   logic [7:0] sb_a[$];
   logic [7:0] sb_b[$];

   logic        rst_a, we_a, tx_a, busy_a, empty_a, full_a, drop_a;
   logic [31:0] data_a;
   logic        rst_b, we_b, tx_b, busy_b, empty_b, full_b, drop_b;
   logic [31:0] data_b;

   tty_uart_tx #(
      .CLKS_PER_BIT(CpbA),
      .FIFO_DEPTH  (DepthA)
   ) dut_a (
      .clk_i       (clk),
      .rst_n_i     (rst_a),
      .tty_we_i    (we_a),
      .tty_data_i  (data_a),
      .tx_o        (tx_a),
      .busy_o      (busy_a),
      .fifo_empty_o(empty_a),
      .fifo_full_o (full_a),
      .drop_o      (drop_a)
   );

   tty_uart_tx dut_b (
      .clk_i       (clk),
      .rst_n_i     (rst_b),
      .tty_we_i    (we_b),
      .tty_data_i  (data_b),
      .tx_o        (tx_b),
      .busy_o      (busy_b),
      .fifo_empty_o(empty_b),
      .fifo_full_o (full_b),
      .drop_o      (drop_b)
   );

   // Line monitor for dut_a: every cycle of every bit must match the expected level.
   initial begin : mon_a
      logic [7:0] exp_byte;
      logic [9:0] frame;
      bit ok, abort;
      int bad_k;
      logic bad_v;
      forever begin
         @(negedge clk);
         if (rst_a === 1'b1 && !abort_a && tx_a === 1'b0) begin
            if (sb_a.size() == 0) begin
               tests_run++; tests_failed++;
               $display("FAIL mon_a_unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
               repeat (10 * CpbA - 1) @(negedge clk);
            end else begin
               exp_byte = sb_a.pop_front();
               frame = {1'b1, exp_byte, 1'b0};
               ok = 1'b1; abort = 1'b0; bad_k = 0; bad_v = 1'b0;
               for (int k = 0; k < 10; k++) begin
                  for (int c = 0; c < int'(CpbA); c++) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (rst_a !== 1'b1 || abort_a) begin
                        abort = 1'b1;
                        break;
                     end
                     if (ok && tx_a !== frame[k]) begin
                        ok = 1'b0; bad_k = k; bad_v = tx_a;
                     end
                  end
                  if (abort) break;
               end
               if (!abort) begin
                  tests_run++;
                  frames_a++;
                  if (!ok) begin
                     tests_failed++;
                     $display("FAIL mon_a_frame byte 0x%02h: bit %0d tx_o=%b, expected %b",
                              exp_byte, bad_k, bad_v, frame[bad_k]);
                  end
               end
            end
         end
      end
   end

   // Line monitor for dut_b (default baud).
   initial begin : mon_b
      logic [7:0] exp_byte;
      logic [9:0] frame;
      bit ok;
      int bad_k;
      logic bad_v;
      forever begin
         @(negedge clk);
         if (rst_b === 1'b1 && tx_b === 1'b0) begin
            if (sb_b.size() == 0) begin
               tests_run++; tests_failed++;
               $display("FAIL mon_b_unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
               repeat (10 * CpbB - 1) @(negedge clk);
            end else begin
               exp_byte = sb_b.pop_front();
               frame = {1'b1, exp_byte, 1'b0};
               ok = 1'b1; bad_k = 0; bad_v = 1'b0;
               for (int k = 0; k < 10; k++) begin
                  for (int c = 0; c < int'(CpbB); c++) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (ok && tx_b !== frame[k]) begin
                        ok = 1'b0; bad_k = k; bad_v = tx_b;
                     end
                  end
               end
               tests_run++;
               frames_b++;
               if (!ok) begin
                  tests_failed++;
                  $display("FAIL mon_b_frame byte 0x%02h: bit %0d tx_o=%b, expected %b",
                           exp_byte, bad_k, bad_v, frame[bad_k]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (tx_a !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_o: got %b, expected 1", tx_a); end
      tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_o: got %b, expected 0", busy_a); end
      tests_run++; if (empty_a !== 1'b1) begin tests_failed++; $display("FAIL reset_fifo_empty_o: got %b, expected 1", empty_a); end
      tests_run++; if (full_a !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_full_o: got %b, expected 0", full_a); end
      tests_run++; if (drop_a !== 1'b0) begin tests_failed++; $display("FAIL reset_drop_o: got %b, expected 0", drop_a); end
      tests_run++; if (tx_b !== 1'b1 || empty_b !== 1'b1) begin
         tests_failed++; $display("FAIL reset_b_idle: tx_o=%b empty=%b, expected 1 1", tx_b, empty_b);
      end
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int n;
      int f0;
      f0 = frames_a;
      @(negedge clk); we_a = 1'b1; data_a = 32'h0000_00A5; sb_a.push_back(8'hA5);
      @(negedge clk); we_a = 1'b0;
      tests_run++; if (empty_a !== 1'b0) begin tests_failed++; $display("FAIL single_empty_after_push: got %b, expected 0", empty_a); end
      @(negedge clk);
      tests_run++; if (empty_a !== 1'b1) begin tests_failed++; $display("FAIL single_empty_after_pop: got %b, expected 1", empty_a); end
      tests_run++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
         tests_failed++; $display("FAIL single_start_latency: tx_o=%b busy_o=%b, expected 0 1", tx_a, busy_a);
      end
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (busy_a !== 1'b1) break;
         n++;
         @(negedge clk);
      end
      tests_run++; if (n != 40) begin tests_failed++; $display("FAIL single_busy_len: got %0d, expected 40", n); end
      repeat (3) @(negedge clk);
      tests_run++; if (frames_a - f0 != 1 || sb_a.size() != 0) begin
         tests_failed++; $display("FAIL single_frames: got %0d (left %0d), expected 1 (left 0)", frames_a - f0, sb_a.size());
      end
   endtask

   task automatic test_upper_bits();
      int n;
      int f0;
      f0 = frames_a;
      @(negedge clk); we_a = 1'b1; data_a = 32'hDEAD_BE41; sb_a.push_back(8'h41);
      @(negedge clk); we_a = 1'b0;
      @(negedge clk);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (busy_a !== 1'b1) break;
         tests_run++; if (drop_a !== 1'b0 || full_a !== 1'b0) begin
            tests_failed++; $display("FAIL upper_side_effect: drop=%b full=%b, expected 0 0", drop_a, full_a);
         end
         n++;
         @(negedge clk);
      end
      tests_run++; if (n != 40) begin tests_failed++; $display("FAIL upper_busy_len: got %0d, expected 40", n); end
      repeat (3) @(negedge clk);
      tests_run++; if (frames_a - f0 != 1 || sb_a.size() != 0) begin
         tests_failed++; $display("FAIL upper_frames: got %0d (left %0d), expected 1 (left 0)", frames_a - f0, sb_a.size());
      end
   endtask

   task automatic test_overflow();
      int unsigned t0;
      int unsigned tfall;
      int f0;
      f0 = frames_a;
      t0 = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) t0 = cyc;
         if (i == 2) begin
            tests_run++; if (empty_a !== 1'b0) begin tests_failed++; $display("FAIL overflow_count1_empty: got %b, expected 0", empty_a); end
         end
         if (i == 4) begin
            tests_run++; if (full_a !== 1'b0) begin tests_failed++; $display("FAIL overflow_count3_full: got %b, expected 0", full_a); end
         end
         if (i == 5) begin
            tests_run++; if (full_a !== 1'b1) begin tests_failed++; $display("FAIL overflow_count4_full: got %b, expected 1", full_a); end
         end
         we_a = 1'b1; data_a = 32'(i + 1);
         if (i < 5) sb_a.push_back(8'(i + 1));
      end
      @(negedge clk); we_a = 1'b0;
      tests_run++; if (drop_a !== 1'b1) begin tests_failed++; $display("FAIL overflow_drop_pulse: got %b, expected 1", drop_a); end
      @(negedge clk);
      tests_run++; if (drop_a !== 1'b0) begin tests_failed++; $display("FAIL overflow_drop_once: got %b, expected 0", drop_a); end
      while (busy_a === 1'b1 && cyc < t0 + 1000) @(negedge clk);
      tfall = cyc;
      tests_run++; if (tfall - (t0 + 1) != 200) begin
         tests_failed++; $display("FAIL overflow_busy_len: got %0d, expected 200", tfall - (t0 + 1));
      end
      repeat (3) @(negedge clk);
      tests_run++; if (frames_a - f0 != 5 || sb_a.size() != 0) begin
         tests_failed++; $display("FAIL overflow_frames: got %0d (left %0d), expected 5 (left 0)", frames_a - f0, sb_a.size());
      end
   endtask

   task automatic test_drain();
      int n;
      int f0;
      f0 = frames_a;
      @(negedge clk); we_a = 1'b1; data_a = 32'h0000_0000; sb_a.push_back(8'h00);
      @(negedge clk); data_a = 32'h0000_00FF; sb_a.push_back(8'hFF);
      @(negedge clk); we_a = 1'b0;
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (busy_a !== 1'b1) break;
         if (n == 39) begin
            tests_run++; if (empty_a !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_before_pop2: got %b, expected 0", empty_a); end
         end
         if (n == 40) begin
            tests_run++; if (empty_a !== 1'b1) begin tests_failed++; $display("FAIL drain_empty_after_pop2: got %b, expected 1", empty_a); end
         end
         n++;
         @(negedge clk);
      end
      tests_run++; if (n != 80) begin tests_failed++; $display("FAIL drain_busy_len: got %0d, expected 80", n); end
      repeat (3) @(negedge clk);
      tests_run++; if (frames_a - f0 != 2 || sb_a.size() != 0) begin
         tests_failed++; $display("FAIL drain_frames: got %0d (left %0d), expected 2 (left 0)", frames_a - f0, sb_a.size());
      end
   endtask

   task automatic test_reset_mid();
      int unsigned t0;
      int n;
      int f0;
      f0 = frames_a;
      @(negedge clk); we_a = 1'b1; data_a = 32'h0000_003C; sb_a.push_back(8'h3C);
      @(negedge clk); t0 = cyc; data_a = 32'h0000_005A; sb_a.push_back(8'h5A);
      @(negedge clk); data_a = 32'h0000_0096; sb_a.push_back(8'h96);
      @(negedge clk); we_a = 1'b0;
      // Edge t0+19 falls inside data bit 3 (START t0+1..t0+4, bit k from t0+5+4k).
      while (cyc < t0 + 18) @(negedge clk);
      abort_a = 1'b1; rst_a = 1'b0; sb_a.delete();
      @(negedge clk); rst_a = 1'b1;
      tests_run++; if (tx_a !== 1'b1) begin tests_failed++; $display("FAIL midreset_tx_o: got %b, expected 1", tx_a); end
      tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy_o: got %b, expected 0", busy_a); end
      tests_run++; if (empty_a !== 1'b1) begin tests_failed++; $display("FAIL midreset_empty: got %b, expected 1", empty_a); end
      @(negedge clk); abort_a = 1'b0;
      n = 0;
      repeat (200) begin
         @(negedge clk);
         if (busy_a !== 1'b0 || tx_a !== 1'b1) n++;
      end
      tests_run++; if (n != 0) begin tests_failed++; $display("FAIL midreset_quiet: got %0d active cycles, expected 0", n); end
      tests_run++; if (frames_a != f0) begin tests_failed++; $display("FAIL midreset_frames: got %0d, expected 0", frames_a - f0); end
   endtask

   task automatic test_default_baud();
      int unsigned t0;
      int unsigned tfall;
      int n_low;
      int n_high;
      int f0;
      f0 = frames_b;
      @(negedge clk); we_b = 1'b1; data_b = 32'h0000_0055; sb_b.push_back(8'h55);
      @(negedge clk); we_b = 1'b0; t0 = cyc;
      for (int i = 0; i < 100; i++) begin
         if (tx_b === 1'b0) break;
         @(negedge clk);
      end
      n_low = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_b !== 1'b0) break;
         n_low++;
         @(negedge clk);
      end
      n_high = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_b !== 1'b1) break;
         n_high++;
         @(negedge clk);
      end
      tests_run++; if (n_low != 16 || n_high != 16) begin
         tests_failed++; $display("FAIL default_bit_len: low %0d high %0d, expected 16 16", n_low, n_high);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); we_b = 1'b1; data_b = 32'h11 * 32'(i + 1); sb_b.push_back(8'(8'h11 * (i + 1)));
      end
      @(negedge clk); we_b = 1'b0;
      tests_run++; if (full_b !== 1'b1) begin tests_failed++; $display("FAIL default_fill_full: got %b, expected 1", full_b); end
      // First frame's STOP->START pop happens on edge t0+161.
      while (cyc < t0 + 160) @(negedge clk);
      we_b = 1'b1; data_b = 32'h0000_0099;
      @(negedge clk);
      tests_run++; if (drop_b !== 1'b1) begin tests_failed++; $display("FAIL default_pop_drop: got %b, expected 1", drop_b); end
      tests_run++; if (full_b !== 1'b0 || empty_b !== 1'b0) begin
         tests_failed++; $display("FAIL default_count3_flags: full=%b empty=%b, expected 0 0", full_b, empty_b);
      end
      data_b = 32'h0000_0077; sb_b.push_back(8'h77);
      @(negedge clk); we_b = 1'b0;
      tests_run++; if (full_b !== 1'b1 || drop_b !== 1'b0) begin
         tests_failed++; $display("FAIL default_count3_refill: full=%b drop=%b, expected 1 0", full_b, drop_b);
      end
      while (busy_b === 1'b1 && cyc < t0 + 3000) @(negedge clk);
      tfall = cyc;
      tests_run++; if (tfall - (t0 + 1) != 960) begin
         tests_failed++; $display("FAIL default_busy_len: got %0d, expected 960", tfall - (t0 + 1));
      end
      repeat (3) @(negedge clk);
      tests_run++; if (frames_b - f0 != 6 || sb_b.size() != 0) begin
         tests_failed++; $display("FAIL default_frames: got %0d (left %0d), expected 6 (left 0)", frames_b - f0, sb_b.size());
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst_a = 1'b0; we_a = 1'b0; data_a = '0;
      rst_b = 1'b0; we_b = 1'b0; data_b = '0;
      test_reset();
      test_single();
      test_upper_bits();
      test_overflow();
      test_drain();
      test_reset_mid();
      test_default_baud();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
